// File: rtl/drr_dequeue_ctrl.sv
// DRR dequeue controller: pops the granted flow's head packet from its show-ahead FIFO and
// streams it with SOP/EOP framing, holding off further grants until the EOP word is accepted.
module drr_dequeue_ctrl #(
    parameter int unsigned PKT_QS_CNT = 4,
    parameter int unsigned DATA_W     = 32,
    localparam int unsigned BPW       = DATA_W / 8,
    localparam int unsigned FLOW_W    = (PKT_QS_CNT > 1) ? $clog2(PKT_QS_CNT) : 1,
    localparam int unsigned BYTES_W   = $clog2(BPW) + 1
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [FLOW_W-1:0]        sched_read_i,
    input  logic                     sched_val_i,
    output logic                     sched_ready_o,
    input  logic [PKT_QS_CNT-1:0]    q_empty_i,
    input  logic [PKT_QS_CNT*16-1:0] q_len_i,
    input  logic [PKT_QS_CNT*DATA_W-1:0] q_data_i,
    output logic [PKT_QS_CNT-1:0]    q_rd_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_sop_o,
    output logic                     out_eop_o,
    output logic [BYTES_W-1:0]       out_bytes_o,
    output logic [FLOW_W-1:0]        out_flow_o,
    output logic                     grant_err_o
);

    localparam int unsigned BPW_LOG = $clog2(BPW);

    typedef enum logic {StIdle = 1'b0, StStream = 1'b1} state_e;

    state_e               r_state;
    logic [FLOW_W-1:0]    r_flow;
    logic [16:0]          r_words_left;
    logic [BYTES_W-1:0]   r_last_bytes;
    logic                 r_first;
    logic                 r_grant_err;

    logic [15:0]          w_q_len  [PKT_QS_CNT];
    logic [DATA_W-1:0]    w_q_data [PKT_QS_CNT];

    for (genvar g = 0; g < PKT_QS_CNT; g++) begin : g_unpack
        assign w_q_len[g]  = q_len_i[g*16 +: 16];
        assign w_q_data[g] = q_data_i[g*DATA_W +: DATA_W];
    end

    // 17-bit sum so a 0xFFFF-byte packet rounds up without wrapping.
    logic [15:0]        w_len;
    logic [16:0]        w_words_raw;
    logic [16:0]        w_words;
    logic [15:0]        w_rem;
    logic [BYTES_W-1:0] w_last_bytes;

    assign w_len        = w_q_len[sched_read_i];
    assign w_words_raw  = ({1'b0, w_len} + 17'(BPW - 1)) >> BPW_LOG;
    assign w_words      = (w_words_raw == 17'd0) ? 17'd1 : w_words_raw;
    assign w_rem        = w_len & 16'(BPW - 1);
    assign w_last_bytes = (w_rem == 16'd0) ? BYTES_W'(BPW) : BYTES_W'(w_rem);

    logic w_idle, w_grant_ok, w_grant_bad, w_valid, w_last, w_xfer;

    assign w_idle      = (r_state == StIdle);
    assign w_grant_ok  = w_idle && sched_val_i && !q_empty_i[sched_read_i];
    assign w_grant_bad = w_idle && sched_val_i && q_empty_i[sched_read_i];
    assign w_valid     = (r_state == StStream) && !q_empty_i[r_flow];
    assign w_last      = (r_words_left == 17'd1);
    assign w_xfer      = w_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            r_state      <= StIdle;
            r_flow       <= '0;
            r_words_left <= '0;
            r_last_bytes <= '0;
            r_first      <= 1'b0;
            r_grant_err  <= 1'b0;
        end else begin
            r_grant_err <= w_grant_bad;
            case (r_state)
                StIdle: begin
                    if (w_grant_ok) begin
                        r_flow       <= sched_read_i;
                        r_words_left <= w_words;
                        r_last_bytes <= w_last_bytes;
                        r_first      <= 1'b1;
                        r_state      <= StStream;
                    end
                end
                StStream: begin
                    if (w_xfer) begin
                        r_words_left <= r_words_left - 17'd1;
                        r_first      <= 1'b0;
                        if (w_last) begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        sched_ready_o = w_idle;
        grant_err_o   = r_grant_err;
        q_rd_o        = '0;
        out_valid_o   = 1'b0;
        out_data_o    = '0;
        out_flow_o    = '0;
        out_sop_o     = 1'b0;
        out_eop_o     = 1'b0;
        out_bytes_o   = '0;
        if (r_state == StStream) begin
            out_valid_o = w_valid;
            out_data_o  = w_q_data[r_flow];
            out_flow_o  = r_flow;
            out_sop_o   = r_first && w_valid;
            out_eop_o   = w_last && w_valid;
            out_bytes_o = w_last ? r_last_bytes : BYTES_W'(BPW);
            if (w_xfer) begin
                q_rd_o[r_flow] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drr_dequeue_ctrl.sv
// Randomized bench for drr_dequeue_ctrl: per-flow FIFOs with numbered words, checked against a
// packet-level model (beats expected per granted packet, length latched at grant).
module tb_drr_dequeue_ctrl;

    localparam int NQ = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [1:0]      sched_read;
    logic            sched_val;
    logic            sched_ready;
    logic [NQ-1:0]   q_empty;
    logic [NQ*16-1:0] q_len;
    logic [NQ*DW-1:0] q_data;
    logic [NQ-1:0]   q_rd;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;
    logic [2:0]      out_bytes;
    logic [1:0]      out_flow;
    logic            grant_err;

    drr_dequeue_ctrl #(
        .PKT_QS_CNT(NQ),
        .DATA_W    (DW)
    ) u_dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .sched_read_i (sched_read),
        .sched_val_i  (sched_val),
        .sched_ready_o(sched_ready),
        .q_empty_i    (q_empty),
        .q_len_i      (q_len),
        .q_data_i     (q_data),
        .q_rd_o       (q_rd),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sop_o    (out_sop),
        .out_eop_o    (out_eop),
        .out_bytes_o  (out_bytes),
        .out_flow_o   (out_flow),
        .grant_err_o  (grant_err)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Stimulus knobs (percentages) and one-shot controls.
    int unsigned p_empty, p_ready, p_val, p_len;
    bit          g_force, g_rst, g_chk_zero;
    int          g_force_flow;

    // Per-flow FIFO contents: word k of flow f is word_of(f, k); cnt = words popped so far.
    int unsigned lens [NQ];
    int unsigned cnt  [NQ];

    // Packet-level reference: one packet in flight, beats numbered 0..m_total-1.
    bit          m_busy, m_err;
    int          m_flow;
    int unsigned m_total, m_idx, m_last, m_base;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int f, input int unsigned c);
        return {8'(f + 1), 24'(c)};
    endfunction

    function automatic int unsigned rand_len();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return $urandom_range(1, 4);
            default: return $urandom_range(5, 48);
        endcase
    endfunction

    task automatic step();
        bit exp_valid, exp_xfer;
        @(negedge clk);
        arst_n = !g_rst;
        for (int f = 0; f < NQ; f++) begin
            if ($urandom_range(0, 99) < p_len) lens[f] = rand_len();
            q_empty[f]            = ($urandom_range(0, 99) < p_empty);
            q_len[f*16 +: 16]     = 16'(lens[f]);
            q_data[f*DW +: DW]    = word_of(f, cnt[f]);
        end
        if (g_force) begin
            sched_val  = 1'b1;
            sched_read = 2'(g_force_flow);
        end else begin
            sched_val  = ($urandom_range(0, 99) < p_val);
            sched_read = 2'($urandom_range(0, NQ - 1));
        end
        out_ready = g_rst ? 1'b0 : ($urandom_range(0, 99) < p_ready);
        #1;
        exp_valid = m_busy && !q_empty[m_flow];
        exp_xfer  = exp_valid && out_ready;
        chk("ready", sched_ready, !m_busy);
        chk("valid", out_valid, exp_valid);
        chk("grant_err", grant_err, m_err);
        chk("q_rd", q_rd, exp_xfer ? (64'd1 << m_flow) : 64'd0);
        chk("sop", out_sop, exp_valid && (m_idx == 0));
        chk("eop", out_eop, exp_valid && (m_idx == m_total - 1));
        if (m_busy) chk("flow", out_flow, m_flow);
        if (exp_valid) begin
            chk("data", out_data, word_of(m_flow, m_base + m_idx));
            chk("bytes", out_bytes, (m_idx == m_total - 1) ? m_last : 4);
        end
        if (g_chk_zero) chk("rst_zero", {out_data, out_bytes, out_flow}, 64'd0);
        for (int f = 0; f < NQ; f++) if (q_rd[f]) cnt[f]++;
        if (g_rst) begin
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = !m_busy && sched_val && q_empty[sched_read];
            if (!m_busy) begin
                if (sched_val && !q_empty[sched_read]) begin
                    m_busy  = 1'b1;
                    m_flow  = int'(sched_read);
                    m_total = (lens[m_flow] == 0) ? 1 : (lens[m_flow] + 3) / 4;
                    m_last  = (lens[m_flow] % 4 == 0) ? 4 : lens[m_flow] % 4;
                    m_idx   = 0;
                    m_base  = cnt[m_flow];
                end
            end else if (exp_xfer) begin
                m_idx++;
                if (m_idx == m_total) m_busy = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int unsigned budget;
        p_val = 0; p_empty = 0; p_ready = 100;
        budget = 0;
        while (m_busy && budget < 200) begin
            step();
            budget++;
        end
    endtask

    initial begin
        int unsigned base3, budget;
        arst_n = 1'b0; sched_val = 1'b0; sched_read = '0; out_ready = 1'b0;
        q_empty = '0; q_len = '0; q_data = '0;
        p_empty = 0; p_ready = 0; p_val = 0; p_len = 0;
        g_force = 1'b0; g_rst = 1'b0; g_chk_zero = 1'b0; g_force_flow = 0;
        m_busy = 1'b0; m_err = 1'b0; m_flow = 0; m_total = 0; m_idx = 0; m_last = 0; m_base = 0;
        for (int f = 0; f < NQ; f++) begin
            cnt[f]  = 0;
            lens[f] = rand_len();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", sched_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_q_rd", q_rd, 64'd0);
        chk("rst_err", grant_err, 1'b0);
        chk("rst_outs", {out_data, out_sop, out_eop, out_bytes, out_flow}, 64'd0);

        // Random traffic: underruns, backpressure, empty-queue grants, mid-packet len changes.
        p_empty = 20; p_ready = 70; p_val = 40; p_len = 5;
        repeat (3000) step();
        drain();

        // Maximum length packet on flow 3.
        p_len = 0;
        lens[3] = 32'hFFFF;
        base3 = cnt[3];
        g_force = 1'b1; g_force_flow = 3;
        step();
        g_force = 1'b0;
        budget = 0;
        while (m_busy && budget < 17000) begin
            step();
            budget++;
        end
        chk("long_pops", cnt[3] - base3, 16384);

        // Reset after 2 of 5 beats.
        lens[0] = 20;
        g_force = 1'b1; g_force_flow = 0;
        step();
        g_force = 1'b0;
        budget = 0;
        while (m_busy && m_idx < 2 && budget < 50) begin
            step();
            budget++;
        end
        g_rst = 1'b1;
        step();
        g_rst = 1'b0;
        g_chk_zero = 1'b1;
        step();
        g_chk_zero = 1'b0;

        p_empty = 20; p_ready = 70; p_val = 40; p_len = 5;
        repeat (1500) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drr_dequeue_ctrl.md
# drr_dequeue_ctrl

Dequeue controller between the deficit round robin scheduler and the per-flow packet FIFOs. It accepts one grant (flow index) at a time from the scheduler and pops that flow's head packet word by word from a show-ahead FIFO. It streams the packet on a valid/ready output with SOP/EOP framing and holds scheduler `ready` low until the packet's last word has been accepted downstream.

## Interface

**Parameters**
- `PKT_QS_CNT`, default 4: number of flows/queues; must match the scheduler.
- `DATA_W`, default 32: word width in bits; must be a multiple of 8.
- `BPW`, derived as `DATA_W/8`: bytes per word; must be a power of 2.

**Ports**
- `clk_i`, in, 1: clock.
- `arst_n_i`, in, 1: reset; synchronous, active-low.
- `sched_read_i`, in, `$clog2(PKT_QS_CNT)`: granted flow index.
- `sched_val_i`, in, 1: grant valid.
- `sched_ready_o`, out, 1: controller can accept a grant; drives scheduler `ready`.
- `q_empty_i`, in, `PKT_QS_CNT`: per-flow FIFO empty.
- `q_len_i`, in, `PKT_QS_CNT` x 16: head packet length in bytes, per flow.
- `q_data_i`, in, `PKT_QS_CNT` x `DATA_W`: head word per flow; show-ahead, valid when not empty.
- `q_rd_o`, out, `PKT_QS_CNT`: one-hot pop, one word per asserted cycle.
- `out_data_o`, out, `DATA_W`: packet word.
- `out_valid_o`, out, 1: word valid.
- `out_ready_i`, in, 1: downstream accepts.
- `out_sop_o`, out, 1: first word of packet.
- `out_eop_o`, out, 1: last word of packet.
- `out_bytes_o`, out, `$clog2(BPW)+1`: valid bytes in the current word.
- `out_flow_o`, out, `$clog2(PKT_QS_CNT)`: flow of the current packet.
- `grant_err_o`, out, 1: one-cycle pulse when a grant targets an empty queue.

## Operation

- FSM with two states, IDLE and STREAM. Reset state is IDLE.
- IDLE:
  - `sched_ready_o`=1.
  - On `sched_val_i`=1 with `q_empty_i[sched_read_i]`=0: latch `flow_q`=`sched_read_i`, latch `len_q`=`q_len_i[flow_q]`, load `words_left`, set `first_q`=1, go to STREAM.
  - On `sched_val_i`=1 with that queue empty: pulse `grant_err_o` next cycle, stay in IDLE, and discard the grant.
- Word count: `words_left` = (len + BPW − 1) >> log2(BPW).
  - Compute in 17 bits so len=0xFFFF does not overflow.
  - len=0 is treated as 1 word.
- STREAM:
  - `out_valid_o` = !`q_empty_i[flow_q]`.
  - `out_data_o` = `q_data_i[flow_q]`.
  - `out_flow_o` = `flow_q`.
  - `out_sop_o` = `first_q` & `out_valid_o`.
  - `out_eop_o` = (`words_left`==1) & `out_valid_o`.
  - `sched_ready_o`=0.
- Transfer occurs when `out_valid_o` & `out_ready_i`. On a transfer:
  - `q_rd_o[flow_q]`=1 in the same cycle (combinational).
  - `words_left` decrements and `first_q` clears.
  - If the transfer is the EOP word, return to IDLE.
- `out_bytes_o`:
  - BPW on non-EOP words.
  - On the EOP word, len mod BPW, with 0 mapping to BPW; len=0 gives BPW.
- `q_rd_o` is never asserted outside STREAM and never has more than one bit set.
- Grants arriving while `sched_ready_o`=0 are ignored.
- Head length is sampled once at grant. Changes to `q_len_i` mid-packet have no effect.

## Timing

- Reset value of every output is 0, except `sched_ready_o`, which comes out of reset as 1 (IDLE). `flow_q`, `words_left` and `first_q` clear to 0.
- Reset asserted mid-packet: next cycle the FSM is IDLE, no `q_rd_o`, `out_valid_o`=0. The partial packet is abandoned and no EOP is emitted.
- Grant accepted at edge N: STREAM from cycle N+1, so the first word can transfer in cycle N+1.
- Sustained `out_ready_i`=1 with a non-empty queue gives one word per cycle; a W-word packet occupies cycles N+1..N+W.
- EOP transfer at edge M: `sched_ready_o`=1 in cycle M+1. Back-to-back packets therefore have exactly one idle cycle between them.
- Backpressure (`out_ready_i`=0): `out_data_o`, `sop`, `eop` and `bytes` stay stable and no pop occurs.
- FIFO underrun mid-packet (queue empty in STREAM): `out_valid_o`=0 and the controller waits with no timeout. SOP/EOP are held and reappear when data arrives.
- `grant_err_o` is registered: it is high in cycle N+1 only, for a bad grant at edge N.

## Test plan

- **Single-word packet:** reset, `q_len_i[2]`=3, DATA_W=32, grant flow 2 → one beat in cycle N+1 with sop=1, eop=1, bytes=3, flow=2; `q_rd_o`=4'b0100 for one cycle; ready=1 at N+2.
- **Multi-word with backpressure:** len=10, `out_ready_i` toggling 1,0,1,1 → 3 beats; bytes 4,4,2; data held constant during the stall cycle; exactly 3 pops.
- **Empty-queue grant:** grant flow 1 with `q_empty_i[1]`=1 → `grant_err_o`=1 for one cycle, no pops, `out_valid_o` stays 0, `sched_ready_o` stays 1.
- **Length boundaries:** len=0 → 1 beat with bytes=4. len=0xFFFF → 16384 beats, with bytes=3 on the last beat and no count overflow.
- **Underrun and ignored grant:** `q_empty_i` asserted for 2 cycles mid-packet, plus a second grant pulsed during STREAM → valid drops for 2 cycles, the packet completes intact, and the second grant is ignored.
- **Reset mid-packet:** `arst_n_i`=0 after 2 of 5 beats → all outputs 0 next cycle, `sched_ready_o`=1 after release, and the next grant starts with sop=1.
